// File: rtl/ooo_pkg.sv
// Shared definitions for the out-of-order EX-stage divide unit: the f3
// encodings, the functional-unit index, the request packet and the FSM states.
package ooo_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int PREG_W_DEF = 7;
    localparam int ROB_W_DEF  = 3;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam int FU_DIV = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [XLEN_DEF-1:0]   rs1;
        logic [XLEN_DEF-1:0]   rs2;
        logic [2:0]            f3;
        logic [PREG_W_DEF-1:0] rd;
        logic [ROB_W_DEF-1:0]  rob_idx;
    } div_req_t;

    // f3[0] clear means a signed operation (DIV/REM)
    function automatic logic is_signed_op(input logic [2:0] f3);
        return !f3[0];
    endfunction

    // Two's complement magnitude when the value is flagged negative
    function automatic logic [XLEN_DEF-1:0] magnitude(input logic neg, input logic [XLEN_DEF-1:0] v);
        return neg ? (-v) : v;
    endfunction

endpackage

// File: rtl/div_core_step.sv
// One radix-2 restoring division iteration: shift {rem,quot} left by one,
// trial-subtract the divisor and keep the difference if it did not borrow.
module div_core_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quot_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quot_o
);

    logic [XLEN:0]   rem_shift;
    logic [XLEN+1:0] diff;
    logic            unused_diff_bit;

    // The extra top bit of diff is the borrow; bit XLEN is always zero when
    // the subtraction succeeds because the partial remainder stays below the divisor.
    assign unused_diff_bit = diff[XLEN];

    // Shift-and-subtract with restore on borrow
    always_comb begin
        rem_shift = {rem_i, quot_i[XLEN-1]};
        diff      = {1'b0, rem_shift} - {2'b00, divisor_i};
        if (!diff[XLEN+1]) begin
            rem_o  = diff[XLEN-1:0];
            quot_o = {quot_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o  = rem_shift[XLEN-1:0];
            quot_o = {quot_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_div_unit.sv
// Iterative DIV/DIVU/REM/REMU functional unit. Operands are converted to
// magnitudes on accept, 32 restoring iterations run in CALC, and the sign
// correction is folded into the result register on the way into DONE.
import ooo_pkg::*;

module ex_div_unit #(
    parameter int XLEN   = XLEN_DEF,
    parameter int PREG_W = PREG_W_DEF,
    parameter int ROB_W  = ROB_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_rs1_data,
    input  logic [XLEN-1:0]     in_rs2_data,
    input  logic [2:0]          in_f3,
    input  logic [PREG_W-1:0]   in_rd,
    input  logic [ROB_W-1:0]    in_rob_idx,
    input  logic                mispredict,
    input  logic [2**ROB_W-1:0] flush_mask,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_data,
    output logic [PREG_W-1:0]   out_rd,
    output logic [ROB_W-1:0]    out_rob_idx
);

    localparam logic [5:0] LAST_ITER = 6'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e        state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quot_q, quot_d;
    logic [XLEN-1:0]   divisor_q, divisor_d;
    logic [PREG_W-1:0] rd_q, rd_d;
    logic [ROB_W-1:0]  rob_q, rob_d;
    logic              is_rem_q, is_rem_d;
    logic              neg_quot_q, neg_quot_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   data_q, data_d;

    div_req_t          req;
    logic              unused_f3_msb;
    logic              op_signed;
    logic              rs1_neg;
    logic              rs2_neg;
    logic [XLEN-1:0]   rs1_mag;
    logic [XLEN-1:0]   rs2_mag;
    logic              div_zero;
    logic              overflow;
    logic              accept;
    logic              drop;
    logic              load;
    logic              held_flush;
    logic [XLEN-1:0]   step_rem;
    logic [XLEN-1:0]   step_quot;
    logic [XLEN-1:0]   final_quot;
    logic [XLEN-1:0]   final_rem;

    assign req = '{
        rs1:     in_rs1_data,
        rs2:     in_rs2_data,
        f3:      in_f3,
        rd:      in_rd,
        rob_idx: in_rob_idx
    };

    // Only f3[1:0] matter here: the unit is only ever handed M-extension divides
    assign unused_f3_msb = req.f3[2];

    // Operand preconditioning for the incoming request
    always_comb begin
        op_signed = is_signed_op(req.f3);
        rs1_neg   = op_signed && req.rs1[XLEN-1];
        rs2_neg   = op_signed && req.rs2[XLEN-1];
        rs1_mag   = magnitude(rs1_neg, req.rs1);
        rs2_mag   = magnitude(rs2_neg, req.rs2);
        div_zero  = (req.rs2 == '0);
        overflow  = op_signed && (req.rs1 == INT_MIN) && (req.rs2 == '1);
    end

    // Handshake and flush qualification
    always_comb begin
        in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        accept     = in_valid && in_ready;
        drop       = mispredict && flush_mask[in_rob_idx];
        load       = accept && !drop;
        held_flush = mispredict && flush_mask[rob_q] && (state_q != IDLE);
    end

    div_core_step #(
        .XLEN(XLEN)
    ) u_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quot_o    (step_quot)
    );

    // Sign correction of the last iteration's results
    always_comb begin
        final_quot = neg_quot_q ? (-step_quot) : step_quot;
        final_rem  = neg_rem_q ? (-step_rem) : step_rem;
    end

    // Next-state logic; a load can only happen from IDLE or DONE and always wins
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        divisor_d  = divisor_q;
        rd_d       = rd_q;
        rob_d      = rob_q;
        is_rem_d   = is_rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        data_d     = data_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            CALC: begin
                if (held_flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d  = step_rem;
                    quot_d = step_quot;
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = DONE;
                        data_d  = is_rem_q ? final_rem : final_quot;
                    end
                end
            end
            DONE: begin
                if (held_flush || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            rd_d       = req.rd;
            rob_d      = req.rob_idx;
            is_rem_d   = req.f3[1];
            neg_quot_d = rs1_neg ^ rs2_neg;
            neg_rem_d  = rs1_neg;
            divisor_d  = rs2_mag;
            quot_d     = rs1_mag;
            rem_d      = '0;
            cnt_d      = '0;
            if (div_zero) begin
                state_d = DONE;
                data_d  = req.f3[1] ? req.rs1 : '1;
            end else if (overflow) begin
                state_d = DONE;
                data_d  = req.f3[1] ? '0 : INT_MIN;
            end else begin
                state_d = CALC;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            rd_q       <= '0;
            rob_q      <= '0;
            is_rem_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            divisor_q  <= divisor_d;
            rd_q       <= rd_d;
            rob_q      <= rob_d;
            is_rem_q   <= is_rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            data_q     <= data_d;
        end
    end

    assign out_valid   = (state_q == DONE);
    assign out_data    = data_q;
    assign out_rd      = rd_q;
    assign out_rob_idx = rob_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Scoreboard bench for ex_div_unit: the driver pushes hand-computed results,
// a negedge monitor pops and compares whenever a result is handed over.
import ooo_pkg::*;

module tb_ex_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [2:0]  in_f3;
    logic [6:0]  in_rd;
    logic [2:0]  in_rob_idx;
    logic        mispredict;
    logic [7:0]  flush_mask;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [6:0]  out_rd;
    logic [2:0]  out_rob_idx;

    typedef struct {
        logic [31:0] data;
        logic [6:0]  rd;
        logic [2:0]  rob;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    bit   seen = 1'b0;

    ex_div_unit dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .in_f3       (in_f3),
        .in_rd       (in_rd),
        .in_rob_idx  (in_rob_idx),
        .mispredict  (mispredict),
        .flush_mask  (flush_mask),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_rd      (out_rd),
        .out_rob_idx (out_rob_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    endtask

    // Monitor: latency on first sighting, payload on handover
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (sb.size() == 0) begin
                check_output("unexpected_out_valid", 32'(out_rob_idx), 32'hFFFF_FFFF);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    check_output($sformatf("latency_rd%0d", sb[0].rd), 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                end
                if (out_ready) begin
                    check_output($sformatf("data_rd%0d", sb[0].rd), out_data, sb[0].data);
                    check_output($sformatf("rd_rd%0d", sb[0].rd), 32'(out_rd), 32'(sb[0].rd));
                    check_output($sformatf("rob_rd%0d", sb[0].rd), 32'(out_rob_idx), 32'(sb[0].rob));
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic apply_stimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                  input logic [6:0] rd, input logic [2:0] rob,
                                  input logic [31:0] result, input int lat, input bit expect_out);
        exp_t e;
        int   n;
        n = 0;
        @(posedge clk); #1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check_output("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid    = 1'b1;
        in_f3       = f3;
        in_rs1_data = a;
        in_rs2_data = b;
        in_rd       = rd;
        in_rob_idx  = rob;
        if (expect_out) begin
            e.data = result;
            e.rd   = rd;
            e.rob  = rob;
            e.lat  = lat;
            e.acc  = cyc;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired pending=%0d", sb.size());
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mispredict = 1'b0; flush_mask = '0;
        in_rs1_data = '0; in_rs2_data = '0; in_f3 = F3_DIV; in_rd = '0; in_rob_idx = '0;
        #2;
        check_output("reset_out_valid", 32'(out_valid), 32'd0);
        check_output("reset_out_data", out_data, 32'd0);
        check_output("reset_out_rd", 32'(out_rd), 32'd0);
        check_output("reset_out_rob", 32'(out_rob_idx), 32'd0);
        check_output("reset_in_ready", 32'(in_ready), 32'd1);
        #10 rst = 1'b1;

        // Normal and special-case arithmetic
        apply_stimulus(F3_DIV,  32'h0000_0064, 32'h0000_0007, 7'd1, 3'd1, 32'h0000_000E, 33, 1'b1);
        apply_stimulus(F3_REM,  32'h0000_0064, 32'h0000_0007, 7'd2, 3'd2, 32'h0000_0002, 33, 1'b1);
        apply_stimulus(F3_REM,  32'hFFFF_FFF9, 32'h0000_0002, 7'd3, 3'd3, 32'hFFFF_FFFF, 33, 1'b1);
        apply_stimulus(F3_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, 7'd4, 3'd4, 32'h7FFF_FFFC, 33, 1'b1);
        apply_stimulus(F3_DIV,  32'hFFFF_FF9C, 32'h0000_0007, 7'd5, 3'd5, 32'hFFFF_FFF2, 33, 1'b1);
        apply_stimulus(F3_DIVU, 32'h0000_1234, 32'h0000_0000, 7'd6, 3'd6, 32'hFFFF_FFFF, 1, 1'b1);
        apply_stimulus(F3_REM,  32'h0000_1234, 32'h0000_0000, 7'd7, 3'd7, 32'h0000_1234, 1, 1'b1);
        apply_stimulus(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 7'd8, 3'd0, 32'h8000_0000, 1, 1'b1);
        apply_stimulus(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 7'd9, 3'd1, 32'h0000_0000, 1, 1'b1);
        wait_drain();

        // Flush of the held op at CALC cycle 10
        apply_stimulus(F3_DIV, 32'h0000_0064, 32'h0000_0007, 7'd20, 3'd5, 32'h0, 33, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        mispredict = 1'b1; flush_mask = 8'h20;
        @(posedge clk); #1;
        mispredict = 1'b0; flush_mask = '0;
        check_output("flush_out_valid", 32'(out_valid), 32'd0);
        check_output("flush_in_ready", 32'(in_ready), 32'd1);
        repeat (40) begin @(posedge clk); #1; end

        // Mispredict that does not cover the held tag
        apply_stimulus(F3_DIV, 32'h0000_0064, 32'h0000_0007, 7'd21, 3'd5, 32'h0000_000E, 33, 1'b1);
        repeat (9) begin @(posedge clk); #1; end
        mispredict = 1'b1; flush_mask = 8'h10;
        @(posedge clk); #1;
        mispredict = 1'b0; flush_mask = '0;
        wait_drain();

        // Accept dropped because its own tag is being squashed
        mispredict = 1'b1; flush_mask = 8'h08;
        apply_stimulus(F3_DIVU, 32'h0000_0010, 32'h0000_0000, 7'd22, 3'd3, 32'h0, 1, 1'b0);
        mispredict = 1'b0; flush_mask = '0;
        check_output("drop_out_valid", 32'(out_valid), 32'd0);
        check_output("drop_in_ready", 32'(in_ready), 32'd1);
        repeat (5) begin @(posedge clk); #1; end

        // Backpressure in DONE followed by a back-to-back accept
        out_ready = 1'b0;
        apply_stimulus(F3_DIVU, 32'h0000_1234, 32'h0000_0000, 7'd9, 3'd2, 32'hFFFF_FFFF, 1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check_output("stall_out_valid", 32'(out_valid), 32'd1);
            check_output("stall_out_data", out_data, 32'hFFFF_FFFF);
            check_output("stall_out_rd", 32'(out_rd), 32'd9);
            check_output("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_f3       = F3_REM;
        in_rs1_data = 32'h0000_0064;
        in_rs2_data = 32'h0000_0007;
        in_rd       = 7'd10;
        in_rob_idx  = 3'd3;
        #1;
        check_output("b2b_in_ready", 32'(in_ready), 32'd1);
        e.data = 32'h0000_0002; e.rd = 7'd10; e.rob = 3'd3; e.lat = 33; e.acc = cyc;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain();

        // Asynchronous reset in the middle of CALC
        apply_stimulus(F3_REM, 32'h0000_0064, 32'h0000_0007, 7'd12, 3'd4, 32'h0, 33, 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        check_output("midreset_out_valid", 32'(out_valid), 32'd0);
        check_output("midreset_out_data", out_data, 32'd0);
        check_output("midreset_out_rd", 32'(out_rd), 32'd0);
        check_output("midreset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (40) begin @(posedge clk); #1; end
        check_output("post_reset_idle", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
